// File: rtl/frame_slicer.sv
// frame_slicer: latches one encoder-side frame and one decoder-side frame,
// then streams them out on two independent valid/ready channels. The TX
// channel carries one info bit per beat; the RX channel carries STEPS
// received symbols per beat, each symbol in its own 3-bit lane.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module frame_slicer #(
  parameter int FRAME_LEN = 128,
  parameter int STEPS     = 2,
  parameter int LANE      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_code_rate,
  input  logic                      i_load,
  output logic                      o_ready,
  input  logic [FRAME_LEN-1:0]      i_encoder_data_frame,
  input  logic [FRAME_LEN*LANE-1:0] i_decoder_data_frame,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_tx_data,
  output logic                      o_rx_valid,
  input  logic                      i_rx_ready,
  output logic [STEPS*LANE-1:0]     o_rx_data,
  output logic                      o_done
);

  localparam int DW       = FRAME_LEN * LANE;
  localparam int BW       = STEPS * LANE;
  localparam int RX_BEATS = FRAME_LEN / STEPS;
  localparam int TXCW     = $clog2(FRAME_LEN + 1);
  localparam int RXCW     = $clog2(RX_BEATS + 1);
  localparam int SHW      = $clog2(STEPS * 3 + 1);
  localparam logic [SHW-1:0] SHAMT_R2 = SHW'(STEPS * 2);
  localparam logic [SHW-1:0] SHAMT_R3 = SHW'(STEPS * 3);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic                 rate_reg;       // latched code rate for the running frame
  logic [FRAME_LEN-1:0] tx_shift_reg;   // info bits not yet placed on o_tx_data, MSB next
  logic [DW-1:0]        rx_shift_reg;   // symbols not yet placed on o_rx_data, MSB next
  logic [TXCW-1:0]      tx_cnt_reg;     // index of the TX beat currently offered
  logic [RXCW-1:0]      rx_cnt_reg;     // index of the RX beat currently offered
  logic                 tx_valid_reg;
  logic                 tx_data_reg;
  logic                 rx_valid_reg;
  logic [BW-1:0]        rx_data_reg;
  logic                 ready_reg;
  logic                 done_reg;

  logic                 load_accept;
  logic                 tx_fire;
  logic                 rx_fire;
  logic                 tx_last;
  logic                 rx_last;
  logic                 tx_fin;
  logic                 rx_fin;
  logic                 rate3_sel;
  logic [SHW-1:0]       rx_shamt;
  logic [BW-1:0]        pack_top;
  logic [BW-1:0]        beat_next;

  assign load_accept = (state_reg == IDLE) && i_load;
  assign tx_fire     = tx_valid_reg && i_tx_ready;
  assign rx_fire     = rx_valid_reg && i_rx_ready;
  assign tx_last     = (tx_cnt_reg == TXCW'(FRAME_LEN - 1));
  assign rx_last     = (rx_cnt_reg == RXCW'(RX_BEATS - 1));
  assign tx_fin      = !tx_valid_reg || (i_tx_ready && tx_last);
  assign rx_fin      = !rx_valid_reg || (i_rx_ready && rx_last);

  // On the load edge the incoming frame and rate feed the first beat directly.
  assign rate3_sel = load_accept ? (i_code_rate == `CODE_RATE_3) : rate_reg;
  assign rx_shamt  = rate3_sel ? SHAMT_R3 : SHAMT_R2;
  assign pack_top  = load_accept ? i_decoder_data_frame[DW-1 -: BW]
                                 : rx_shift_reg[DW-1 -: BW];

  // Lane packing: pack_top[BW-1] is the earliest bit; within each lane the
  // earliest bit lands in lane bit 0, and lane bit 2 is zero at rate 1/2.
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_lane
    assign beat_next[gi*LANE + 0] = rate3_sel ? pack_top[BW-1 - (gi*3 + 0)]
                                              : pack_top[BW-1 - (gi*2 + 0)];
    assign beat_next[gi*LANE + 1] = rate3_sel ? pack_top[BW-1 - (gi*3 + 1)]
                                              : pack_top[BW-1 - (gi*2 + 1)];
    assign beat_next[gi*LANE + 2] = rate3_sel ? pack_top[BW-1 - (gi*3 + 2)]
                                              : 1'b0;
  end

  // FSM next state: finish when both streams have delivered their last beat.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_load) state_next = RUN;
      RUN:     if (tx_fin && rx_fin) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered ready/done decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      rate_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == IDLE);
      done_reg  <= (state_next == DONE);
      if (load_accept) rate_reg <= (i_code_rate == `CODE_RATE_3);
    end
  end

  // TX stream: one info bit per beat, MSB first, held while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift_reg <= '0;
      tx_cnt_reg   <= '0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 1'b0;
    end else if (load_accept) begin
      tx_shift_reg <= i_encoder_data_frame << 1;
      tx_cnt_reg   <= '0;
      tx_valid_reg <= 1'b1;
      tx_data_reg  <= i_encoder_data_frame[FRAME_LEN-1];
    end else if (tx_fire) begin
      if (tx_last) begin
        tx_valid_reg <= 1'b0;
        tx_data_reg  <= 1'b0;
        tx_cnt_reg   <= '0;
      end else begin
        tx_data_reg  <= tx_shift_reg[FRAME_LEN-1];
        tx_shift_reg <= tx_shift_reg << 1;
        tx_cnt_reg   <= tx_cnt_reg + 1'b1;
      end
    end
  end

  // RX stream: STEPS symbols per beat, consuming 2 or 3 bits per symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift_reg <= '0;
      rx_cnt_reg   <= '0;
      rx_valid_reg <= 1'b0;
      rx_data_reg  <= '0;
    end else if (load_accept) begin
      rx_shift_reg <= i_decoder_data_frame << rx_shamt;
      rx_cnt_reg   <= '0;
      rx_valid_reg <= 1'b1;
      rx_data_reg  <= beat_next;
    end else if (rx_fire) begin
      if (rx_last) begin
        rx_valid_reg <= 1'b0;
        rx_data_reg  <= '0;
        rx_cnt_reg   <= '0;
      end else begin
        rx_data_reg  <= beat_next;
        rx_shift_reg <= rx_shift_reg << rx_shamt;
        rx_cnt_reg   <= rx_cnt_reg + 1'b1;
      end
    end
  end

  assign o_ready    = ready_reg;
  assign o_done     = done_reg;
  assign o_tx_valid = tx_valid_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_rx_valid = rx_valid_reg;
  assign o_rx_data  = rx_data_reg;

endmodule

// File: tb/tb_frame_slicer.sv
// Directed testbench for frame_slicer (FRAME_LEN=128, STEPS=2).
`timescale 1ns/1ps

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_frame_slicer;

  localparam int FL = 128;
  localparam int ST = 2;
  localparam int LN = 3;
  localparam int DW = FL * LN;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_code_rate = `CODE_RATE_2;
  logic          i_load = 1'b0;
  logic          o_ready;
  logic [FL-1:0] i_encoder_data_frame = '0;
  logic [DW-1:0] i_decoder_data_frame = '0;
  logic          o_tx_valid;
  logic          i_tx_ready = 1'b1;
  logic          o_tx_data;
  logic          o_rx_valid;
  logic          i_rx_ready = 1'b1;
  logic [5:0]    o_rx_data;
  logic          o_done;

  always #5 clk = ~clk;

  frame_slicer #(.FRAME_LEN(FL), .STEPS(ST), .LANE(LN)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_code_rate          (i_code_rate),
    .i_load               (i_load),
    .o_ready              (o_ready),
    .i_encoder_data_frame (i_encoder_data_frame),
    .i_decoder_data_frame (i_decoder_data_frame),
    .o_tx_valid           (o_tx_valid),
    .i_tx_ready           (i_tx_ready),
    .o_tx_data            (o_tx_data),
    .o_rx_valid           (o_rx_valid),
    .i_rx_ready           (i_rx_ready),
    .o_rx_data            (o_rx_data),
    .o_done               (o_done)
  );

  int total = 0;
  int bad   = 0;

  // Stream recorder: a beat seen with valid&ready at the falling edge
  // transfers at the following rising edge.
  int         cyc = 0, tx_n = 0, rx_n = 0, done_n = 0;
  int         last_rx_cyc = 0, done_cyc = 0;
  logic       tx_bits [2048];
  logic [5:0] rx_beats [1024];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (o_tx_valid && i_tx_ready) begin
        tx_bits[tx_n & 2047] = o_tx_data;
        tx_n++;
      end
      if (o_rx_valid && i_rx_ready) begin
        rx_beats[rx_n & 1023] = o_rx_data;
        rx_n++;
        last_rx_cyc = cyc;
      end
      if (o_done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [FL-1:0] enc, input logic [DW-1:0] dec, input logic rate);
    drive_edge();
    i_encoder_data_frame = enc;
    i_decoder_data_frame = dec;
    i_code_rate          = rate;
    i_load               = 1'b1;
    drive_edge();
    i_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      tick();
      if (o_ready) break;
    end
    chk(tag, 64'(i < bound), 64'd1);
  endtask

  // Reference packing: beat k, step s, lane bit b takes stream bit k*2n+s*n+b.
  function automatic logic [5:0] exp_beat(input logic [DW-1:0] d, input logic r3, input int k);
    logic [5:0] v;
    int n;
    v = '0;
    n = r3 ? 3 : 2;
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < n; b++)
        v[s*3 + b] = d[DW-1 - (k*2*n + s*n + b)];
    return v;
  endfunction

  task automatic check_frame(input string tag, input logic [FL-1:0] enc, input logic [DW-1:0] dec,
                             input logic r3, input int txb, input int rxb, input int db);
    int tx_err, rx_err;
    tx_err = 0;
    rx_err = 0;
    for (int i = 0; i < FL; i++)
      if (tx_bits[(txb + i) & 2047] !== enc[FL-1-i]) tx_err++;
    for (int k = 0; k < FL/ST; k++)
      if (rx_beats[(rxb + k) & 1023] !== exp_beat(dec, r3, k)) rx_err++;
    chk({tag, "_tx_count"}, 64'(tx_n - txb), 64'd128);
    chk({tag, "_rx_count"}, 64'(rx_n - rxb), 64'd64);
    chk({tag, "_done_count"}, 64'(done_n - db), 64'd1);
    chk({tag, "_tx_seq_errs"}, 64'(tx_err), 64'd0);
    chk({tag, "_rx_seq_errs"}, 64'(rx_err), 64'd0);
    $display("frame %s: tx_beats=%0d rx_beats=%0d done=%0d tx_errs=%0d rx_errs=%0d",
             tag, tx_n - txb, rx_n - rxb, done_n - db, tx_err, rx_err);
  endtask

  initial begin
    logic [FL-1:0] enc_a, enc_b, enc_c, enc_d, enc_e, enc_f, enc_g1, enc_g2;
    logic [DW-1:0] dec_a, dec_b, dec_c, dec_d, dec_e, dec_f, dec_g1, dec_g2;
    int   txb, rxb, db, idx, i;
    logic held;
    logic [5:0] held_rx;

    enc_a  = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    dec_a  = {4'b1011, {95{4'b0110}}};
    enc_b  = 128'hA5A5_1234_5678_9ABC_DEF0_0F1E_2D3C_3C3C;
    dec_b  = {6'b110100, {62{6'b000111}}, 6'b101101};
    enc_c  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F0E1_D2C3;
    dec_c  = {{48{8'h5A}}};
    enc_d  = 128'h0F0F_F0F0_1111_2222_3333_4444_5555_6666;
    dec_d  = {{32{12'hC39}}};
    enc_e  = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    dec_e  = {{96{4'h9}}};
    enc_f  = 128'h8123_4567_89AB_CDEF_0011_2233_4455_6677;
    dec_f  = {{24{16'hB4E1}}};
    enc_g1 = 128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0;
    dec_g1 = {{64{6'b100110}}};
    enc_g2 = 128'hC001_D00D_CAFE_BABE_0BAD_F00D_1234_ABCD;
    dec_g2 = {{48{8'h3C}}};

    // Reset state
    tick();
    chk("rst_ready",    64'(o_ready),    64'd1);
    chk("rst_tx_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_tx_data",  64'(o_tx_data),  64'd0);
    chk("rst_rx_valid", 64'(o_rx_valid), 64'd0);
    chk("rst_rx_data",  64'(o_rx_data),  64'd0);
    chk("rst_done",     64'(o_done),     64'd0);
    drive_edge();
    rst = 1'b1;
    tick();

    // Frame A: rate 1/2, both readies high
    txb = tx_n; rxb = rx_n; db = done_n;
    do_load(enc_a, dec_a, `CODE_RATE_2);
    tick();
    chk("a_first_tx_valid", 64'(o_tx_valid), 64'd1);
    chk("a_first_rx_valid", 64'(o_rx_valid), 64'd1);
    chk("a_ready_low",      64'(o_ready),    64'd0);
    wait_idle("a_idle_timeout", 400);
    chk("a_tx_bit0",   64'(tx_bits[txb & 2047]),         64'd1);
    chk("a_tx_bit1",   64'(tx_bits[(txb + 1) & 2047]),   64'd0);
    chk("a_tx_bit127", 64'(tx_bits[(txb + 127) & 2047]), 64'd1);
    chk("a_rx_first",  64'(rx_beats[rxb & 1023]),        64'b011_001);
    check_frame("A", enc_a, dec_a, 1'b0, txb, rxb, db);

    // Frame B: rate 1/3
    txb = tx_n; rxb = rx_n; db = done_n;
    do_load(enc_b, dec_b, `CODE_RATE_3);
    wait_idle("b_idle_timeout", 400);
    chk("b_rx_first", 64'(rx_beats[rxb & 1023]),        64'b001_011);
    chk("b_rx_last",  64'(rx_beats[(rxb + 63) & 1023]), 64'b101_101);
    check_frame("B", enc_b, dec_b, 1'b1, txb, rxb, db);

    // Frame C: inputs disturbed during RUN, then a 5-cycle TX stall
    txb = tx_n; rxb = rx_n; db = done_n;
    do_load(enc_c, dec_c, `CODE_RATE_2);
    repeat (10) drive_edge();
    i_load = 1'b1;
    i_code_rate = `CODE_RATE_3;
    i_encoder_data_frame = ~enc_c;
    i_decoder_data_frame = ~dec_c;
    tick();
    chk("c_ready_in_run", 64'(o_ready), 64'd0);
    drive_edge();
    i_load = 1'b0;
    repeat (15) drive_edge();
    i_tx_ready = 1'b0;
    tick();
    held = o_tx_data;
    idx  = tx_n - txb;
    chk("c_stall_bit", 64'(held), 64'(enc_c[FL-1-idx]));
    for (i = 0; i < 4; i++) begin
      tick();
      chk("c_stall_data",  64'(o_tx_data),  64'(held));
      chk("c_stall_valid", 64'(o_tx_valid), 64'd1);
    end
    chk("c_stall_count", 64'(tx_n - txb), 64'(idx));
    drive_edge();
    i_tx_ready = 1'b1;
    tick();
    chk("c_ready_after_stall", 64'(o_ready), 64'd0);
    wait_idle("c_idle_timeout", 400);
    check_frame("C", enc_c, dec_c, 1'b0, txb, rxb, db);
    i_code_rate = `CODE_RATE_2;

    // Frame D: RX held off until TX has finished
    txb = tx_n; rxb = rx_n; db = done_n;
    i_rx_ready = 1'b0;
    do_load(enc_d, dec_d, `CODE_RATE_2);
    tick();
    held_rx = o_rx_data;
    repeat (135) tick();
    chk("d_tx_finished", 64'(o_tx_valid),    64'd0);
    chk("d_rx_pending",  64'(o_rx_valid),    64'd1);
    chk("d_rx_held",     64'(o_rx_data),     64'(held_rx));
    chk("d_rx_first",    64'(o_rx_data),     64'(exp_beat(dec_d, 1'b0, 0)));
    chk("d_no_early_done", 64'(done_n - db), 64'd0);
    drive_edge();
    i_rx_ready = 1'b1;
    wait_idle("d_idle_timeout", 400);
    chk("d_done_after_last_rx", 64'(done_cyc), 64'(last_rx_cyc + 1));
    check_frame("D", enc_d, dec_d, 1'b0, txb, rxb, db);

    // Frames G1/G2: i_load held high gives back-to-back frames
    txb = tx_n; rxb = rx_n; db = done_n;
    drive_edge();
    i_encoder_data_frame = enc_g1;
    i_decoder_data_frame = dec_g1;
    i_code_rate = `CODE_RATE_3;
    i_load = 1'b1;
    drive_edge();
    i_encoder_data_frame = enc_g2;
    i_decoder_data_frame = dec_g2;
    i_code_rate = `CODE_RATE_2;
    wait_idle("g1_idle_timeout", 400);
    check_frame("G1", enc_g1, dec_g1, 1'b1, txb, rxb, db);
    txb = tx_n; rxb = rx_n; db = done_n;
    tick();
    chk("g2_started_ready", 64'(o_ready),    64'd0);
    chk("g2_started_valid", 64'(o_tx_valid), 64'd1);
    chk("g2_first_bit",     64'(o_tx_data),  64'(enc_g2[FL-1]));
    i_load = 1'b0;
    wait_idle("g2_idle_timeout", 400);
    check_frame("G2", enc_g2, dec_g2, 1'b0, txb, rxb, db);

    // Frame E: reset at TX beat 40
    txb = tx_n; rxb = rx_n; db = done_n;
    do_load(enc_e, dec_e, `CODE_RATE_3);
    for (i = 0; i < 300; i++) begin
      tick();
      if (tx_n - txb >= 40) break;
    end
    chk("e_reach_beat40", 64'(i < 300), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("e_rst_tx_valid", 64'(o_tx_valid), 64'd0);
    chk("e_rst_tx_data",  64'(o_tx_data),  64'd0);
    chk("e_rst_rx_valid", 64'(o_rx_valid), 64'd0);
    chk("e_rst_rx_data",  64'(o_rx_data),  64'd0);
    chk("e_rst_done",     64'(o_done),     64'd0);
    chk("e_rst_ready",    64'(o_ready),    64'd1);
    drive_edge();
    drive_edge();
    rst = 1'b1;
    repeat (3) tick();
    chk("e_no_done", 64'(done_n - db), 64'd0);
    $display("frame E: aborted by reset after %0d tx beats", tx_n - txb);

    // Frame F: fresh frame after the aborted one
    txb = tx_n; rxb = rx_n; db = done_n;
    do_load(enc_f, dec_f, `CODE_RATE_2);
    tick();
    chk("f_first_bit", 64'(o_tx_data), 64'(enc_f[FL-1]));
    wait_idle("f_idle_timeout", 400);
    check_frame("F", enc_f, dec_f, 1'b0, txb, rxb, db);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
